// File: rtl/scanner_pkg.sv
// Shared encodings for the scanner lab: one-hot display status codes and FSM state type.
package scanner_pkg;

  localparam logic [4:0] ST_IDLE  = 5'b01000;
  localparam logic [4:0] ST_SCAN  = 5'b10000;
  localparam logic [4:0] ST_XFER  = 5'b00100;
  localparam logic [4:0] ST_FLUSH = 5'b00001;
  localparam logic [4:0] ST_READY = 5'b00010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_READY = 3'd2,
    S_XFER  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  function automatic logic [4:0] status_of(input state_e s);
    case (s)
      S_SCAN:  return ST_SCAN;
      S_READY: return ST_READY;
      S_XFER:  return ST_XFER;
      S_FLUSH: return ST_FLUSH;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Phase prescaler: one-cycle tick every TICK_DIV cycles, restartable via clr.
module tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;

  assign tick = (count_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_controller.sv
// Scanner sequencing FSM: scan, hold (READY), word transfer and flush phases
// paced by a prescaled tick, with registered display status and progress.
module scan_controller
  import scanner_pkg::*;
#(
  parameter int TICK_DIV    = 50_000,
  parameter int SCAN_STEPS  = 10,
  parameter int FLUSH_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       xfer_req,
  input  logic       flush_req,
  output logic [4:0] status,
  output logic [3:0] progress,
  output logic       buf_full,
  output logic       xfer_valid,
  output logic [3:0] xfer_word,
  output logic       busy
);

  localparam int FCNT_W = (FLUSH_TICKS > 1) ? $clog2(FLUSH_TICKS) : 1;
  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_TICKS - 1);
  localparam logic [3:0]        SCAN_LAST  = 4'(SCAN_STEPS - 1);
  localparam logic [3:0]        SCAN_WORDS = 4'(SCAN_STEPS);

  state_e            state_q, state_d;
  logic [3:0]        progress_q, progress_d;
  logic              buf_full_q, buf_full_d;
  logic              xfer_valid_q, xfer_valid_d;
  logic [3:0]        xfer_word_q, xfer_word_d;
  logic [3:0]        idx_q, idx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [4:0]        status_q;
  logic              busy_q;
  logic              tick;

  // Prescaler restarts on every state change so each phase gets a full first tick.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_d != state_q),
    .tick    (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    progress_d   = progress_q;
    buf_full_d   = buf_full_q;
    xfer_valid_d = 1'b0;
    xfer_word_d  = xfer_word_q;
    idx_d        = idx_q;
    fcnt_d       = fcnt_q;

    if (flush_req && state_q != S_FLUSH) begin
      state_d    = S_FLUSH;
      progress_d = '0;
      fcnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_SCAN;
            progress_d = '0;
          end
        end
        S_SCAN: begin
          if (tick) begin
            if (progress_q == SCAN_LAST) begin
              state_d    = S_READY;
              buf_full_d = 1'b1;
              progress_d = '0;
            end else begin
              progress_d = progress_q + 1'b1;
            end
          end
        end
        S_READY: begin
          if (xfer_req) begin
            state_d     = S_XFER;
            progress_d  = SCAN_WORDS;
            xfer_word_d = '0;
            idx_d       = '0;
          end
        end
        S_XFER: begin
          if (tick) begin
            xfer_valid_d = 1'b1;
            xfer_word_d  = idx_q;
            idx_d        = idx_q + 1'b1;
            if (progress_q == 4'd1) begin
              state_d    = S_IDLE;
              buf_full_d = 1'b0;
              progress_d = '0;
            end else begin
              progress_d = progress_q - 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (tick) begin
            if (fcnt_q == FLUSH_LAST) begin
              state_d    = S_IDLE;
              buf_full_d = 1'b0;
              progress_d = '0;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          progress_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      progress_q   <= '0;
      buf_full_q   <= 1'b0;
      xfer_valid_q <= 1'b0;
      xfer_word_q  <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      status_q     <= ST_IDLE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      progress_q   <= progress_d;
      buf_full_q   <= buf_full_d;
      xfer_valid_q <= xfer_valid_d;
      xfer_word_q  <= xfer_word_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      status_q     <= status_of(state_d);
      busy_q       <= (state_d == S_SCAN) || (state_d == S_XFER) || (state_d == S_FLUSH);
    end
  end

  assign status     = status_q;
  assign progress   = progress_q;
  assign buf_full   = buf_full_q;
  assign xfer_valid = xfer_valid_q;
  assign xfer_word  = xfer_word_q;
  assign busy       = busy_q;

endmodule
